// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: instruction field widths, opcodes and the
// instruction-queue entry carried between fetch and decode.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [7:0]  lc3b_byte;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [3:0]  lc3b_offset4;
    typedef logic [4:0]  lc3b_offset5;
    typedef logic [5:0]  lc3b_offset6;
    typedef logic [8:0]  lc3b_offset9;
    typedef logic [10:0] lc3b_offset11;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STB  = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_SHF  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } lc3b_opcode;

    typedef struct packed {
        lc3b_word word;
        lc3b_word pc;
    } lc3b_ir_entry;

    localparam int IRQ_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/ir_fields.sv
// Pure combinational slicer splitting an LC-3b instruction word into the
// standard decode fields; reused anywhere decode needs them.
module ir_fields
    import lc3b_types::*;
(
    input  lc3b_word     word,
    output lc3b_opcode   opcode,
    output lc3b_reg      dest,
    output lc3b_reg      src1,
    output lc3b_reg      src2,
    output lc3b_offset4  offset4,
    output lc3b_offset5  offset5,
    output lc3b_offset6  offset6,
    output lc3b_byte     trapvect8,
    output lc3b_offset9  offset9,
    output lc3b_offset11 offset11,
    output logic         d_enable,
    output logic         imm_enable,
    output logic         jsr_enable
);

    assign opcode     = lc3b_opcode'(word[15:12]);
    assign dest       = word[11:9];
    assign src1       = word[8:6];
    assign src2       = word[2:0];
    assign offset4    = word[3:0];
    assign offset5    = word[4:0];
    assign offset6    = word[5:0];
    assign trapvect8  = word[7:0];
    assign offset9    = word[8:0];
    assign offset11   = word[10:0];
    assign d_enable   = word[4];
    assign imm_enable = word[5];
    assign jsr_enable = word[11];

endmodule

// File: rtl/ir_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer
// of {word, pc} with valid/ready on both sides and a one-cycle flush.
module ir_queue
    import lc3b_types::*;
#(
    parameter int DEPTH        = IRQ_DEFAULT_DEPTH,
    parameter bit CLEAR_ON_POP = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  lc3b_word                 in_data,
    input  lc3b_word                 in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output lc3b_word                 out,
    output lc3b_word                 out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output lc3b_opcode               opcode,
    output lc3b_reg                  dest,
    output lc3b_reg                  src1,
    output lc3b_reg                  src2,
    output lc3b_offset4              offset4,
    output lc3b_offset5              offset5,
    output lc3b_offset6              offset6,
    output lc3b_byte                 trapvect8,
    output lc3b_offset9              offset9,
    output lc3b_offset11             offset11,
    output logic                     d_enable,
    output logic                     imm_enable,
    output logic                     jsr_enable
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE    = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    lc3b_ir_entry    mem_r [DEPTH];
    logic [PW-1:0]   wptr_r;
    logic [PW-1:0]   rptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic            in_ready_s;
    logic            out_valid_s;
    logic            push_s;
    logic            pop_s;
    lc3b_ir_entry    head_s;

    // Handshake status depends only on the registered occupancy.
    assign in_ready_s  = (count_r < FULL_COUNT);
    assign out_valid_s = (count_r != {CW{1'b0}});
    assign push_s      = in_valid && in_ready_s;
    assign pop_s       = out_valid_s && out_ready;
    assign head_s      = mem_r[rptr_r];

    // Occupancy update for the four push/pop combinations.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and count registers; flush overrides any handshake in its cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) wptr_r <= wptr_r + PTR_ONE;
            if (pop_s)  rptr_r <= rptr_r + PTR_ONE;
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; push and pop never target the same slot in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else if (!flush) begin
            if (push_s) mem_r[wptr_r] <= '{word: in_data, pc: in_pc};
            if (CLEAR_ON_POP && pop_s) mem_r[rptr_r] <= '0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign count     = count_r;
    assign out       = head_s.word;
    assign out_pc    = head_s.pc;

    ir_fields u_fields (
        .word       (head_s.word),
        .opcode     (opcode),
        .dest       (dest),
        .src1       (src1),
        .src2       (src2),
        .offset4    (offset4),
        .offset5    (offset5),
        .offset6    (offset6),
        .trapvect8  (trapvect8),
        .offset9    (offset9),
        .offset11   (offset11),
        .d_enable   (d_enable),
        .imm_enable (imm_enable),
        .jsr_enable (jsr_enable)
    );

endmodule
